// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory stage and its SRAM controller.
package mem_stage_pkg;
  localparam int          DATA_W          = 32;
  localparam int          HALF_W          = 16;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
  localparam int          DEF_SRAM_ADDR_W = 18;
  localparam int          DEF_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// Two-phase 16-bit SRAM sequencer for 32-bit accesses: 2*WAIT_CYCLES+2 cycles per access,
// holds freeze high until DONE so the request and its operands stay stable upstream.
module mem_stage_sram_ctrl
  import mem_stage_pkg::*;
#(
  parameter int SRAM_ADDR_W = DEF_SRAM_ADDR_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   write,
  input  logic [SRAM_ADDR_W-2:0] word,
  input  logic [DATA_W-1:0]      wdata,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [HALF_W-1:0]      sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [HALF_W-1:0]      sram_dq_in,
  output logic                   sram_we_n,
  output logic                   freeze,
  output logic                   done,
  output logic [DATA_W-1:0]      rdata
);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   wr_q;
  logic [SRAM_ADDR_W-2:0] word_q;
  logic [HALF_W-1:0]      hi_q;

  // Strobe stays low on every cycle but the last of a phase, so the rising
  // edge lands while address and data are still driven.
  function automatic logic strobe(input logic [CNT_W-1:0] c);
    return (WAIT_CYCLES == 1) || (c != LAST);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_q        <= 1'b0;
      word_q      <= '0;
      hi_q        <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      rdata       <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          state       <= LOW;
          cnt         <= '0;
          wr_q        <= write;
          word_q      <= word;
          hi_q        <= wdata[31:16];
          sram_addr   <= {word, 1'b0};
          sram_dq_out <= wdata[15:0];
          sram_dq_oe  <= write;
          sram_we_n   <= ~(write & strobe('0));
        end
        LOW: if (cnt == LAST) begin
          rdata[15:0] <= sram_dq_in;
          state       <= HIGH;
          cnt         <= '0;
          sram_addr   <= {word_q, 1'b1};
          sram_dq_out <= hi_q;
          sram_we_n   <= ~(wr_q & strobe('0));
        end else begin
          cnt       <= cnt + CNT_W'(1);
          sram_we_n <= ~(wr_q & strobe(cnt + CNT_W'(1)));
        end
        HIGH: if (cnt == LAST) begin
          rdata[31:16] <= sram_dq_in;
          state        <= DONE;
          cnt          <= '0;
          sram_dq_oe   <= 1'b0;
          sram_we_n    <= 1'b1;
        end else begin
          cnt       <= cnt + CNT_W'(1);
          sram_we_n <= ~(wr_q & strobe(cnt + CNT_W'(1)));
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by reset so a held request cannot stall the pipeline while in reset.
  assign freeze = rst & req & (state != DONE);
  assign done   = (state == DONE);
endmodule

// File: rtl/mem_stage_sram.sv
// Memory stage + MEM/WB register over a 16-bit SRAM; 1 cycle for ALU ops, 2*WAIT_CYCLES+2 for memory ops.
// Stalls upstream via freeze; define MEM_STAGE_LAST_READ_CACHE_EN for a one-entry last-read cache.
module mem_stage_sram
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          SRAM_ADDR_W = DEF_SRAM_ADDR_W,
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_en_in,
  input  logic                   mem_read_in,
  input  logic                   mem_write_in,
  input  logic [3:0]             dest_in,
  input  logic [DATA_W-1:0]      alu_res_in,
  input  logic [DATA_W-1:0]      val_rm_in,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [HALF_W-1:0]      sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [HALF_W-1:0]      sram_dq_in,
  output logic                   sram_we_n,
  output logic                   freeze,
  output logic                   wb_en_out,
  output logic                   mem_read_out,
  output logic [3:0]             dest_out,
  output logic [DATA_W-1:0]      alu_res_out,
  output logic [DATA_W-1:0]      mem_data_out
);
  logic [DATA_W-1:0]      offset;
  logic [SRAM_ADDR_W-2:0] word;
  logic                   is_load;
  logic                   is_store;
  logic                   hit;
  logic                   req;
  logic                   access_done;
  logic [DATA_W-1:0]      rdata;
  logic [DATA_W-1:0]      load_data;
  logic                   unused_offset_bits;

  // Wraps modulo for addresses below the base; the byte offset within a word is dropped.
  assign offset             = alu_res_in - BASE_ADDR;
  assign word               = offset[SRAM_ADDR_W:2];
  assign unused_offset_bits = ^{offset[DATA_W-1:SRAM_ADDR_W+1], offset[1:0]};

  // Store wins when both control bits are set.
  assign is_store = mem_write_in;
  assign is_load  = mem_read_in & ~mem_write_in;
  assign req      = (mem_read_in | mem_write_in) & ~hit;

`ifdef MEM_STAGE_LAST_READ_CACHE_EN
  logic                   c_valid;
  logic [SRAM_ADDR_W-2:0] c_word;
  logic [DATA_W-1:0]      c_data;

  assign hit       = is_load & c_valid & (c_word == word);
  assign load_data = hit ? c_data : rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_valid <= 1'b0;
      c_word  <= '0;
      c_data  <= '0;
    end else if (access_done) begin
      if (is_load) begin
        c_valid <= 1'b1;
        c_word  <= word;
        c_data  <= rdata;
      end else if (is_store && c_valid && (c_word == word)) begin
        c_data <= val_rm_in;
      end
    end
  end
`else
  logic unused_done;
  assign hit         = 1'b0;
  assign load_data   = rdata;
  assign unused_done = access_done;
`endif

  mem_stage_sram_ctrl #(
    .SRAM_ADDR_W (SRAM_ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .write       (is_store),
    .word        (word),
    .wdata       (val_rm_in),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n),
    .freeze      (freeze),
    .done        (access_done),
    .rdata       (rdata)
  );

  // While frozen, a bubble goes to write-back; payload fields keep their last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_out    <= 1'b0;
      mem_read_out <= 1'b0;
      dest_out     <= '0;
      alu_res_out  <= '0;
      mem_data_out <= '0;
    end else if (freeze) begin
      wb_en_out    <= 1'b0;
      mem_read_out <= 1'b0;
    end else begin
      wb_en_out    <= wb_en_in;
      mem_read_out <= is_load;
      dest_out     <= dest_in;
      alu_res_out  <= alu_res_in;
      if (is_load) mem_data_out <= load_data;
    end
  end
endmodule

// File: tb/tb_mem_stage_sram.sv
// Bench for mem_stage_sram: directed vector table, reset corner cases and random traffic vs a word-level model.
module tb_mem_stage_sram;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int AW = 18;
  localparam int W  = 2;
`ifdef MEM_STAGE_LAST_READ_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam int MEM_FRZ = 2 * W + 1;
  localparam int HIT_FRZ = CACHE ? 0 : MEM_FRZ;
  localparam int WE_LOW  = (W == 1) ? 2 : 2 * (W - 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wb_en_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0;
  logic [3:0]    dest_in = '0;
  logic [31:0]   alu_res_in = '0, val_rm_in = '0;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_we_n, freeze;
  logic          wb_en_out, mem_read_out;
  logic [3:0]    dest_out;
  logic [31:0]   alu_res_out, mem_data_out;

  mem_stage_sram dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .dest_in(dest_in), .alu_res_in(alu_res_in),
    .val_rm_in(val_rm_in), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n),
    .freeze(freeze), .wb_en_out(wb_en_out), .mem_read_out(mem_read_out),
    .dest_out(dest_out), .alu_res_out(alu_res_out), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Half-word SRAM device model.
  logic [15:0] sram [0:(1<<AW)-1];
  assign sram_dq_in = sram[sram_addr];
  always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_dq_out;

  typedef struct {
    logic we, rd, wr;
    logic [3:0] dest;
    logic [31:0] alu, val;
  } instr_t;

  typedef struct {
    instr_t in;
    logic e_wb, e_mr;
    logic [31:0] e_md;
    int e_frz;
  } vec_t;

  int nvec = 0;
  int nbad = 0;

  // Word-level reference state.
  logic [31:0] mwords [int];
  logic [31:0] m_mdata = '0;
  bit          c_valid = 1'b0;
  int          c_word  = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return int'((o >> 2) & ((32'd1 << (AW - 1)) - 32'd1));
  endfunction

  task automatic model(input instr_t i, output logic e_wb, output logic e_mr,
                       output logic [31:0] e_md, output int e_frz);
    int w;
    bit ld, hit;
    w   = word_of(i.alu);
    ld  = i.rd && !i.wr;
    hit = CACHE && ld && c_valid && (c_word == w);
    if (i.wr) mwords[w] = i.val;
    if (ld) begin
      m_mdata = mwords.exists(w) ? mwords[w] : 32'd0;
      c_valid = 1'b1;
      c_word  = w;
    end
    e_wb  = i.we;
    e_mr  = ld;
    e_md  = m_mdata;
    e_frz = ((i.rd || i.wr) && !hit) ? MEM_FRZ : 0;
  endtask

  task automatic drive(input instr_t i);
    wb_en_in = i.we; mem_read_in = i.rd; mem_write_in = i.wr;
    dest_in = i.dest; alu_res_in = i.alu; val_rm_in = i.val;
  endtask

  task automatic check_instr(input string tag, input instr_t i, input logic e_wb,
                             input logic e_mr, input logic [31:0] e_md, input int e_frz);
    int frz, welow, oec, bub, w;
    logic [31:0] a0, a1, d0, d1;
    bit ok;
    frz = 0; welow = 0; oec = 0; bub = 0; ok = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    drive(i);
    for (int c = 0; c < 40; c++) begin
      #1;
      if (c > 0 && (wb_en_out || mem_read_out)) bub++;
      if (sram_dq_oe) oec++;
      if (!sram_we_n) begin
        if (welow == 0) begin a0 = 32'(sram_addr); d0 = 32'(sram_dq_out); end
        a1 = 32'(sram_addr); d1 = 32'(sram_dq_out);
        welow++;
      end
      if (freeze) frz++; else ok = 1'b1;
      @(posedge clk);
      if (ok) break;
    end
    #1;
    chk({tag, ".completed"}, 32'(ok), 32'd1);
    chk({tag, ".wb_en"}, 32'(wb_en_out), 32'(e_wb));
    chk({tag, ".mem_read"}, 32'(mem_read_out), 32'(e_mr));
    chk({tag, ".dest"}, 32'(dest_out), 32'(i.dest));
    chk({tag, ".alu_res"}, alu_res_out, i.alu);
    chk({tag, ".mem_data"}, mem_data_out, e_md);
    chk({tag, ".freeze_cycles"}, 32'(frz), 32'(e_frz));
    if (e_frz > 0) chk({tag, ".bubble"}, 32'(bub), 32'd0);
    if (i.wr) begin
      w = word_of(i.alu);
      chk({tag, ".we_low_cycles"}, 32'(welow), 32'(WE_LOW));
      chk({tag, ".oe_cycles"}, 32'(oec), 32'(2 * W));
      chk({tag, ".lo_addr"}, a0, 32'(2 * w));
      chk({tag, ".lo_data"}, d0, {16'd0, i.val[15:0]});
      chk({tag, ".hi_addr"}, a1, 32'(2 * w + 1));
      chk({tag, ".hi_data"}, d1, {16'd0, i.val[31:16]});
    end else begin
      chk({tag, ".no_write"}, 32'(welow), 32'd0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".we_n"}, 32'(sram_we_n), 32'd1);
    chk({tag, ".oe"}, 32'(sram_dq_oe), 32'd0);
    chk({tag, ".addr"}, 32'(sram_addr), 32'd0);
    chk({tag, ".freeze"}, 32'(freeze), 32'd0);
    chk({tag, ".wb_en"}, 32'(wb_en_out), 32'd0);
    chk({tag, ".mem_read"}, 32'(mem_read_out), 32'd0);
    chk({tag, ".dest"}, 32'(dest_out), 32'd0);
    chk({tag, ".alu_res"}, alu_res_out, 32'd0);
    chk({tag, ".mem_data"}, mem_data_out, 32'd0);
  endtask

  initial begin
    vec_t   tbl [10];
    instr_t i;
    logic   e_wb, e_mr;
    logic [31:0] e_md;
    int     e_frz, t;

    //            we  rd  wr  dest   alu           val                wb  mr  mem_data      frz
    tbl[0] = '{'{1'b1,1'b0,1'b0,4'd5, 32'h00001234, 32'h0},          1'b1,1'b0,32'h00000000,0};
    tbl[1] = '{'{1'b0,1'b0,1'b1,4'd0, 32'd1032,     32'hDEADBEEF},   1'b0,1'b0,32'h00000000,MEM_FRZ};
    tbl[2] = '{'{1'b1,1'b1,1'b0,4'd7, 32'd1033,     32'h0},          1'b1,1'b1,32'hDEADBEEF,MEM_FRZ};
    tbl[3] = '{'{1'b0,1'b1,1'b1,4'd2, 32'd1036,     32'h0000CAFE},   1'b0,1'b0,32'hDEADBEEF,MEM_FRZ};
    tbl[4] = '{'{1'b1,1'b1,1'b0,4'd3, 32'd1036,     32'h0},          1'b1,1'b1,32'h0000CAFE,MEM_FRZ};
    tbl[5] = '{'{1'b1,1'b1,1'b0,4'd4, 32'd1032,     32'h0},          1'b1,1'b1,32'hDEADBEEF,MEM_FRZ};
    tbl[6] = '{'{1'b1,1'b1,1'b0,4'd4, 32'd1032,     32'h0},          1'b1,1'b1,32'hDEADBEEF,HIT_FRZ};
    tbl[7] = '{'{1'b0,1'b0,1'b0,4'd15,32'hFFFFFFFF, 32'h0},          1'b0,1'b0,32'hDEADBEEF,0};
    tbl[8] = '{'{1'b0,1'b0,1'b1,4'd1, 32'd0,        32'h12345678},   1'b0,1'b0,32'hDEADBEEF,MEM_FRZ};
    tbl[9] = '{'{1'b1,1'b1,1'b0,4'd9, 32'd3,        32'h0},          1'b1,1'b1,32'h12345678,MEM_FRZ};

    for (int k = 0; k < (1 << AW); k++) sram[k] = 16'h0000;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;

    for (int k = 0; k < 10; k++) begin
      model(tbl[k].in, e_wb, e_mr, e_md, e_frz);
      check_instr($sformatf("vec%0d", k), tbl[k].in, tbl[k].e_wb, tbl[k].e_mr, tbl[k].e_md, tbl[k].e_frz);
    end

    for (int k = 0; k < 300; k++) begin
      t      = int'($urandom_range(0, 19));
      i.we   = 1'($urandom_range(0, 1));
      i.dest = 4'($urandom_range(0, 15));
      i.val  = $urandom;
      i.rd   = (t >= 8 && t < 14) || t == 19;
      i.wr   = (t >= 14);
      if (i.rd || i.wr) i.alu = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      else              i.alu = $urandom;
      model(i, e_wb, e_mr, e_md, e_frz);
      check_instr($sformatf("rnd%0d", k), i, e_wb, e_mr, e_md, e_frz);
    end

    // Reset while the high half of a store is in flight.
    i = '{1'b1, 1'b0, 1'b1, 4'd6, BASE + 32'd2000, 32'hAAAA5555};
    drive(i);
    repeat (3) @(posedge clk);
    #1;
    chk("midreset.in_high_phase", 32'(sram_addr), 32'(2 * word_of(i.alu) + 1));
    rst = 1'b0;
    #1;
    check_idle_outputs("midreset");
    i = '{1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0};
    drive(i);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_mdata = '0;
    c_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("postreset%0d.freeze", c), 32'(freeze), 32'd0);
      chk($sformatf("postreset%0d.we_n", c), 32'(sram_we_n), 32'd1);
      chk($sformatf("postreset%0d.oe", c), 32'(sram_dq_oe), 32'd0);
    end
    i = '{1'b1, 1'b0, 1'b0, 4'd11, 32'h0000ABCD, 32'h0};
    model(i, e_wb, e_mr, e_md, e_frz);
    check_instr("after_reset_alu", i, e_wb, e_mr, e_md, e_frz);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/mem_stage_sram.md
Name: mem_stage_sram

Overview:
- Memory stage directly downstream of the execute stage; consumes its ALU result (address), store data, destination register and control bits.
- Performs 32-bit loads/stores against an external 16-bit SRAM as two half-word accesses.
- Stalls the upstream pipeline with `freeze` while an access is in flight.
- Contains the MEM/WB pipeline register that feeds write-back.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- SRAM_ADDR_W, 18: SRAM half-word address width.
- WAIT_CYCLES, 2: cycles each SRAM half access is held (≥1).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- wb_en_in, mem_read_in, mem_write_in  input  1 each  control bits from execute.
- dest_in  input  4  destination register.
- alu_res_in  input  32  ALU result / byte address.
- val_rm_in  input  32  store data.
- sram_addr  output  SRAM_ADDR_W  half-word address.
- sram_dq_out  output  16  write data.
- sram_dq_oe  output  1  drive enable for write data.
- sram_dq_in  input  16  read data.
- sram_we_n  output  1  SRAM write strobe, active-low.
- freeze  output  1  stall request to fetch/decode/execute registers.
- wb_en_out, mem_read_out  output  1 each  registered to write-back.
- dest_out  output  4  registered destination.
- alu_res_out  output  32  registered ALU result.
- mem_data_out  output  32  registered load data.

Behaviour:
- Reset (rst=0, any time, including mid-access):
  - FSM to IDLE; wait counter 0.
  - All registered outputs 0; sram_we_n=1, sram_dq_oe=0, sram_addr=0; freeze=0.
- Word index = (alu_res_in − BASE_ADDR) >> 2, truncated to SRAM_ADDR_W−1 bits. Below-base addresses wrap modulo; alu_res_in[1:0] is ignored.
- Half-word addresses:
  - Low half: {word,1'b0}, carries data[15:0].
  - High half: {word,1'b1}, carries data[31:16].
- req = mem_read_in | mem_write_in. If both are set, the write wins and the access is treated as a store.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if req, go to LOW and clear the counter; else stay.
  - LOW: drive the low-half address (and data for a write); hold WAIT_CYCLES cycles, then go to HIGH.
  - HIGH: same for the high half, then go to DONE.
  - DONE: one cycle, then IDLE.
- Writes:
  - sram_dq_oe=1 throughout LOW/HIGH.
  - sram_we_n=0 on every LOW/HIGH cycle except the last of each phase, so address and data are stable when the strobe rises. If WAIT_CYCLES=1, sram_we_n is low for the whole one-cycle phase.
- Reads: sram_dq_in is sampled on the last cycle of each phase into an internal 32-bit read buffer.
- freeze (combinational) = req & (state != DONE). A memory op keeps freeze high for 1+2·WAIT_CYCLES cycles (5 at default). In DONE freeze=0, so upstream advances on that edge.
- MEM/WB register, updated every edge:
  - freeze=1: insert a bubble. wb_en_out=0, mem_read_out=0; other fields hold.
  - Otherwise capture wb_en_in, mem_read_in, dest_in, alu_res_in. mem_data_out = read buffer for a load, else holds.
- Latency:
  - Non-memory op: 1 cycle, no stall.
  - Memory op: 2·WAIT_CYCLES+2 cycles from arrival to the outputs being valid.
- An instruction arriving in the cycle after DONE starts a fresh access; there is no lost or duplicated request.

Optional Feature:
- Macro: MEM_STAGE_LAST_READ_CACHE_EN.
- Defined: a one-entry cache holds {valid, word, data}.
  - A read hitting a valid entry skips the SRAM: no freeze, 1-cycle latency, mem_data_out = cached data.
  - A miss fills the entry in DONE.
  - A write to the same word updates the cached data; a write to another word leaves the entry unchanged.
  - Reset clears valid.
- Undefined: every read goes to the SRAM; no cache logic is present.

Decomposition:
- Package mem_stage_pkg:
  - FSM state enum (IDLE/LOW/HIGH/DONE).
  - Default BASE_ADDR, SRAM_ADDR_W, WAIT_CYCLES.
  - Data/half-word width constants.
- Sub-module sram_ctrl: FSM, wait counter, SRAM pins, read buffer and freeze.
- Top level: address translation, MEM/WB register, optional cache.

Test Plan:
- Reset mid-access: rst=0 during HIGH of a write → sram_we_n=1, freeze=0, all outputs 0; after rst=1 with no request, remains IDLE.
- ALU op, no memory: alu_res_in=0x00001234, wb_en_in=1, dest_in=5 → next edge wb_en_out=1, alu_res_out=0x1234, dest_out=5; freeze never asserted.
- Store: alu_res_in=1032, val_rm_in=0xDEADBEEF, WAIT_CYCLES=2 → addr 4 / dq 0xBEEF, then addr 5 / dq 0xDEAD; sram_we_n low one cycle per half; freeze high exactly 5 cycles.
- Load back: alu_res_in=1033 (misaligned), mem_read_in=1, wb_en_in=1 → mem_data_out=0xDEADBEEF, mem_read_out=1, wb_en_out=1 after the 6th cycle; wb_en_out=0 during the freeze.
- Both read and write set: address 1036, data 0x0000CAFE → store performed; mem_read_out=0; a following load of 1036 returns 0x0000CAFE.
- Cache (macro defined): two consecutive loads of 1032 → first stalls 5 cycles; second completes in 1 cycle with no freeze and returns 0xDEADBEEF.
